// File: rtl/chad_spill_stack.sv
// chad_spill_stack: register-cached LIFO for the chad core. It spills to and fills from
// backing memory, and has sticky overflow/underflow flags.
//
// Build option: define CHAD_STACK_SPILL_EN to enable the spill/fill engine. Without it the
// stack is a plain DEPTH-entry cache. Logical full is then occ = DEPTH, busy is constant 0
// and the memory port is tied off.
//
// Ports:
//   clk, resetq               clock, asynchronous active-low reset
//   hold                      core wait state; suppresses core stack operations
//   delta, we, wd             stack op (00 none, 01 push, 11 pop, 10 pop-two), write new top
//   rd                        top of stack (0 when empty)
//   busy                      requested op cannot complete this cycle
//   depth                     logical depth (cache + memory)
//   ovf, udf, flag_clr        sticky overflow/underflow flags and their clear
//   mem_req/we/addr/wdata     backing-memory request (held stable until mem_ack)
//   mem_rdata, mem_ack        fill data and request completion
module chad_spill_stack #(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned MEMDEPTH = 256,
  parameter int unsigned AW       = $clog2(MEMDEPTH)
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             hold,
  input  logic [1:0]       delta,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic [AW:0]      depth,
  output logic             ovf,
  output logic             udf,
  input  logic             flag_clr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] OccFull = OW'(DEPTH);
  localparam logic [OW-1:0] OccHigh = OW'(DEPTH - 1);

  typedef logic [PW-1:0] idx_t;

  logic [WIDTH-1:0] cache_q [DEPTH];
  logic [WIDTH-1:0] cache_d [DEPTH];
  idx_t             bot_q, bot_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;

  logic [AW-1:0]    mcnt;
  logic             full;
  logic             eng_spill, eng_fill;  // engine request acked this cycle
  logic             push, pop_stall;
  logic [OW-1:0]    pop_n;
  idx_t             top_idx;

  assign push      = (delta == 2'b01);
  assign pop_n     = (delta == 2'b11) ? OW'(1) : (delta == 2'b10) ? OW'(2) : '0;
  // A pop must leave at least one cached entry while memory still holds entries.
  assign pop_stall = (mcnt != '0) && (pop_n != '0) && (occ_q <= pop_n);
  assign top_idx   = bot_q + idx_t'(occ_q) - idx_t'(1);
  assign depth     = {1'b0, mcnt} + (AW+1)'(occ_q);
  assign rd        = (occ_q != '0) ? cache_q[top_idx] : '0;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

`ifdef CHAD_STACK_SPILL_EN
  localparam logic [AW:0]   DepthMax = (AW+1)'(MEMDEPTH);
  localparam logic [AW-1:0] McntMax  = AW'(MEMDEPTH - DEPTH);

  typedef enum logic [1:0] {StIdle, StSpill, StFill} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    mcnt_q, mcnt_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  assign mcnt      = mcnt_q;
  assign full      = (depth == DepthMax);
  assign eng_spill = (state_q == StSpill) && mem_ack;
  assign eng_fill  = (state_q == StFill) && mem_ack;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    busy = 1'b0;
    if (push && !full) begin
      if (occ_q == OccFull) busy = 1'b1;
      // Last free slot is reserved for the fill in flight.
      if (occ_q == OccHigh && state_q == StFill) busy = 1'b1;
    end
    if (pop_stall) busy = 1'b1;
    // The spilling entry at bot must never become the top or be popped.
    if (state_q == StSpill && pop_n != '0 && occ_q <= pop_n + OW'(1)) busy = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (occ_q >= OccHigh && mcnt_q != McntMax) begin
          state_d     = StSpill;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mcnt_q;
          mem_wdata_d = cache_q[bot_q];
        end else if (mcnt_q != '0 && (occ_q <= OW'(1) || pop_stall)) begin
          // A stalled pop-two also triggers a fill, otherwise it could wait forever.
          state_d    = StFill;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = mcnt_q - AW'(1);
        end
      end
      StSpill: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mcnt_d    = mcnt_q + AW'(1);
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      StFill: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mcnt_d    = mcnt_q - AW'(1);
          mem_req_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= StIdle;
      mcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
`else
  logic unused_mem;

  assign unused_mem = mem_ack ^ (^mem_rdata);
  assign mcnt       = '0;
  assign full       = (occ_q == OccFull);
  assign eng_spill  = 1'b0;
  assign eng_fill   = 1'b0;
  assign busy       = 1'b0;
  assign mem_req    = 1'b0;
  assign mem_we     = 1'b0;
  assign mem_addr   = '0;
  assign mem_wdata  = '0;
`endif

  logic          ovf_set, udf_set, wr_en;
  idx_t          wr_idx;
  logic [OW-1:0] core_inc, core_dec;

  always_comb begin
    cache_d  = cache_q;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    core_inc = '0;
    core_dec = '0;
    wr_en    = 1'b0;
    wr_idx   = top_idx;
    if (!hold && !busy) begin
      if (push) begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          core_inc = OW'(1);
          wr_en    = we;
          wr_idx   = bot_q + idx_t'(occ_q);
        end
      end else if (pop_n != '0) begin
        // Only reachable with memory empty, so occ is the logical depth here.
        if (pop_n > occ_q) begin
          udf_set  = 1'b1;
          core_dec = occ_q;
        end else begin
          core_dec = pop_n;
        end
        wr_en  = we && (occ_q != core_dec);
        wr_idx = bot_q + idx_t'(occ_q - core_dec) - idx_t'(1);
      end else begin
        wr_en = we && (occ_q != '0);
      end
    end
    if (wr_en) cache_d[wr_idx] = wd;
    // Fill lands below bot, never on a slot the core can touch.
    if (eng_fill) cache_d[bot_q - idx_t'(1)] = mem_rdata;

    bot_d = bot_q;
    if (eng_spill) bot_d = bot_q + idx_t'(1);
    if (eng_fill)  bot_d = bot_q - idx_t'(1);
    occ_d = occ_q + core_inc - core_dec;
    if (eng_spill) occ_d = occ_d - OW'(1);
    if (eng_fill)  occ_d = occ_d + OW'(1);

    // A set on the same cycle as flag_clr wins.
    ovf_d = ovf_set | (ovf_q & ~flag_clr);
    udf_d = udf_set | (udf_q & ~flag_clr);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cache_q <= '{default: '0};
      bot_q   <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      cache_q <= cache_d;
      bot_q   <= bot_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

endmodule

// File: tb/tb_chad_spill_stack.sv
// Testbench for chad_spill_stack (DEPTH=16, MEMDEPTH=32). It has a behavioural backing
// memory that acks after a short delay and can hold the ack off. Spill-specific scenarios
// are compiled when CHAD_STACK_SPILL_EN is defined; the cache-only full test otherwise.
module tb_chad_spill_stack;
  localparam int unsigned WIDTH    = 18;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned MEMDEPTH = 32;
  localparam int unsigned AW       = 5;

  logic             clk = 1'b0;
  logic             resetq = 1'b0;
  logic             hold = 1'b0;
  logic [1:0]       delta = 2'b00;
  logic             we = 1'b0;
  logic [WIDTH-1:0] wd = '0;
  logic             flag_clr = 1'b0;
  logic [WIDTH-1:0] rd;
  logic             busy;
  logic [AW:0]      depth;
  logic             ovf, udf;
  logic             mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  logic [WIDTH-1:0]    mem [MEMDEPTH];
  int unsigned         ack_cnt;
  bit                  ack_block = 1'b0;
  logic [AW+WIDTH-1:0] spill_obs [$];
  logic [WIDTH-1:0]    spill_exp [$];
  logic [WIDTH-1:0]    exp_q [$];
  int                  checks = 0;
  int                  errors = 0;
  int                  stall_total = 0;
  int                  req_seen = 0;

  chad_spill_stack #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .MEMDEPTH(MEMDEPTH),
    .AW      (AW)
  ) dut (
    .clk      (clk),
    .resetq   (resetq),
    .hold     (hold),
    .delta    (delta),
    .we       (we),
    .wd       (wd),
    .rd       (rd),
    .busy     (busy),
    .depth    (depth),
    .ovf      (ovf),
    .udf      (udf),
    .flag_clr (flag_clr),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  // Backing memory: ack two cycles after the request is seen, unless held off.
  assign mem_ack   = mem_req && !ack_block && (ack_cnt >= 2);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ack_cnt <= 0;
    end else if (mem_req && mem_ack) begin
      ack_cnt <= 0;
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        spill_obs.push_back({mem_addr, mem_wdata});
      end
    end else if (mem_req) begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge after the op has executed.
  task automatic core_op(input logic [1:0] d, input logic w, input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    delta = d;
    we = w;
    wd = v;
    #1;
    if (mem_req) req_seen++;
    while (busy && n < 300) begin
      @(negedge clk);
      #1;
      n++;
      if (mem_req) req_seen++;
    end
    stall_total += n;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL core_op_stall busy=%0d required 0 within 300 cycles", busy);
    end
    @(posedge clk);
    @(negedge clk);
    delta = 2'b00;
    we = 1'b0;
  endtask

  task automatic push_val(input logic [WIDTH-1:0] v);
    core_op(2'b01, 1'b1, v);
    exp_q.push_back(v);
    spill_exp.push_back(v);
  endtask

  task automatic pop_chk();
    logic [WIDTH-1:0] e;
    e = exp_q.pop_back();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL pop_rd got %0d required %0d", rd, e);
    end
    core_op(2'b11, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    delta = 2'b00;
    we = 1'b0;
    hold = 1'b0;
    flag_clr = 1'b0;
    ack_block = 1'b0;
    exp_q.delete();
    spill_exp.delete();
    spill_obs.delete();
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL reset_rd got %0d required 0", rd); end
    checks++;
    if (depth !== '0) begin errors++; $display("FAIL reset_depth got %0d required 0", depth); end
    checks++;
    if ({busy, ovf, udf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags busy/ovf/udf got %b required 000", {busy, ovf, udf});
    end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem req=%0d we=%0d addr=%0d wdata=%0d required all 0",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    do_reset();
  endtask

  task automatic test_push5();
    do_reset();
    req_seen = 0;
    for (int i = 1; i <= 5; i++) push_val(WIDTH'(i));
    checks++;
    if (rd !== 18'd5) begin errors++; $display("FAIL push5_rd got %0d required 5", rd); end
    checks++;
    if (depth !== 6'd5) begin errors++; $display("FAIL push5_depth got %0d required 5", depth); end
    idle(4);
    checks++;
    if (req_seen != 0) begin
      errors++;
      $display("FAIL push5_mem_req got %0d request cycles required 0", req_seen);
    end
    for (int i = 0; i < 5; i++) pop_chk();
    checks++;
    if (depth !== '0) begin errors++; $display("FAIL push5_end_depth got %0d required 0", depth); end
  endtask

  task automatic test_write_ops();
    do_reset();
    push_val(18'd10);
    push_val(18'd20);
    core_op(2'b00, 1'b1, 18'd33);
    void'(exp_q.pop_back());
    exp_q.push_back(18'd33);
    checks++;
    if (rd !== exp_q[$]) begin errors++; $display("FAIL we_top rd got %0d required %0d", rd, exp_q[$]); end
    checks++;
    if (depth !== 6'd2) begin errors++; $display("FAIL we_top_depth got %0d required 2", depth); end
    core_op(2'b11, 1'b1, 18'd44);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exp_q.push_back(18'd44);
    checks++;
    if (rd !== exp_q[$]) begin errors++; $display("FAIL we_pop rd got %0d required %0d", rd, exp_q[$]); end
    checks++;
    if (depth !== 6'd1) begin errors++; $display("FAIL we_pop_depth got %0d required 1", depth); end
    hold = 1'b1;
    delta = 2'b01;
    we = 1'b1;
    wd = 18'd55;
    @(posedge clk);
    @(negedge clk);
    hold = 1'b0;
    delta = 2'b00;
    we = 1'b0;
    checks++;
    if (depth !== 6'd1 || rd !== 18'd44) begin
      errors++;
      $display("FAIL hold depth=%0d rd=%0d required depth 1 rd 44", depth, rd);
    end
  endtask

  task automatic test_underflow();
    // Entered with depth 1 from test_write_ops.
    core_op(2'b10, 1'b0, '0);
    exp_q.delete();
    checks++;
    if (udf !== 1'b1) begin errors++; $display("FAIL pop2_udf got %0d required 1", udf); end
    checks++;
    if (depth !== '0) begin errors++; $display("FAIL pop2_depth got %0d required 0", depth); end
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL pop2_rd got %0d required 0", rd); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL pop2_ovf got %0d required 0", ovf); end
    flag_clr = 1'b1;
    core_op(2'b11, 1'b0, '0);
    flag_clr = 1'b0;
    checks++;
    if (udf !== 1'b1) begin errors++; $display("FAIL clr_vs_set udf got %0d required 1", udf); end
    flag_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flag_clr = 1'b0;
    checks++;
    if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear got %0d required 0", udf); end
  endtask

`ifdef CHAD_STACK_SPILL_EN
  task automatic test_spill_fill();
    logic [AW+WIDTH-1:0] obs;
    logic [WIDTH-1:0]    e;
    int                  k;
    do_reset();
    for (int i = 1; i <= 20; i++) push_val(WIDTH'(i));
    idle(20);
    checks++;
    if (depth !== 6'd20) begin errors++; $display("FAIL spill_depth got %0d required 20", depth); end
    checks++;
    if (spill_obs.size() != 6) begin
      errors++;
      $display("FAIL spill_count got %0d required 6", spill_obs.size());
    end
    k = 0;
    while (spill_obs.size() > 0 && spill_exp.size() > 0) begin
      obs = spill_obs.pop_front();
      e = spill_exp.pop_front();
      checks++;
      if (obs !== {AW'(k), e}) begin
        errors++;
        $display("FAIL spill_write addr=%0d data=%0d required addr %0d data %0d",
                 obs[AW+WIDTH-1:WIDTH], obs[WIDTH-1:0], k, e);
      end
      k++;
    end
    for (int i = 0; i < 20; i++) pop_chk();
    req_seen = 0;
    idle(10);
    checks++;
    if (depth !== '0) begin errors++; $display("FAIL fill_end_depth got %0d required 0", depth); end
    checks++;
    if (req_seen != 0 || spill_obs.size() != 0) begin
      errors++;
      $display("FAIL fill_end_idle req_cycles=%0d spills=%0d required 0 0", req_seen,
               spill_obs.size());
    end
  endtask

  task automatic test_busy_ackhold();
    int n_busy;
    int n;
    do_reset();
    ack_block = 1'b1;
    for (int i = 1; i <= 16; i++) push_val(WIDTH'(i));
    checks++;
    if (depth !== 6'd16 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL hold_off_setup depth=%0d mem_req=%0d required 16 1", depth, mem_req);
    end
    delta = 2'b01;
    we = 1'b1;
    wd = 18'd17;
    n_busy = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (busy) n_busy++;
      @(negedge clk);
    end
    checks++;
    if (n_busy != 4) begin errors++; $display("FAIL busy_full got %0d busy cycles required 4", n_busy); end
    checks++;
    if (depth !== 6'd16 || mem_addr !== '0 || mem_wdata !== 18'd1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL spill_stable depth=%0d addr=%0d wdata=%0d we=%0d required 16 0 1 1",
               depth, mem_addr, mem_wdata, mem_we);
    end
    ack_block = 1'b0;
    n = 0;
    #1;
    while (busy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n == 0 || n >= 50) begin
      errors++;
      $display("FAIL busy_release got %0d stall cycles after ack release required 1..49", n);
    end
    @(posedge clk);
    @(negedge clk);
    delta = 2'b00;
    we = 1'b0;
    exp_q.push_back(18'd17);
    checks++;
    if (depth !== 6'd17) begin errors++; $display("FAIL busy_push_depth got %0d required 17", depth); end
    idle(10);
    for (int i = 0; i < 17; i++) pop_chk();
    // Reset during an outstanding request.
    ack_block = 1'b1;
    for (int i = 1; i <= 15; i++) push_val(WIDTH'(i));
    idle(2);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req got %0d required 1", mem_req); end
    resetq = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || depth !== '0) begin
      errors++;
      $display("FAIL reset_mid_req mem_req=%0d depth=%0d required 0 0", mem_req, depth);
    end
    do_reset();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 32; i++) push_val(WIDTH'(i));
    checks++;
    if (depth !== 6'd32 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill depth=%0d ovf=%0d required 32 0", depth, ovf);
    end
    core_op(2'b01, 1'b1, 18'd33);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0d required 1", ovf); end
    checks++;
    if (depth !== 6'd32 || rd !== 18'd32) begin
      errors++;
      $display("FAIL ovf_discard depth=%0d rd=%0d required 32 32", depth, rd);
    end
    flag_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flag_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0d required 0", ovf); end
    for (int i = 0; i < 3; i++) pop_chk();
  endtask
`else
  task automatic test_nospill_full();
    do_reset();
    stall_total = 0;
    req_seen = 0;
    for (int i = 1; i <= 16; i++) push_val(WIDTH'(i));
    checks++;
    if (depth !== 6'd16 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL cache_full depth=%0d ovf=%0d required 16 0", depth, ovf);
    end
    core_op(2'b01, 1'b1, 18'd17);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL nospill_ovf got %0d required 1", ovf); end
    checks++;
    if (depth !== 6'd16 || rd !== 18'd16) begin
      errors++;
      $display("FAIL nospill_discard depth=%0d rd=%0d required 16 16", depth, rd);
    end
    checks++;
    if (stall_total != 0 || req_seen != 0) begin
      errors++;
      $display("FAIL nospill_quiet busy_cycles=%0d req_cycles=%0d required 0 0", stall_total,
               req_seen);
    end
    flag_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flag_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL nospill_clear got %0d required 0", ovf); end
    for (int i = 0; i < 16; i++) pop_chk();
    checks++;
    if (depth !== '0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL nospill_end depth=%0d mem_req=%0d required 0 0", depth, mem_req);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_push5();
    test_write_ops();
    test_underflow();
`ifdef CHAD_STACK_SPILL_EN
    test_spill_fill();
    test_busy_ackhold();
    test_overflow();
`else
    test_nospill_full();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
